// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte-stream input and decoded-packet outputs of the PS/2 mouse packet decoder.
// master = byte source / consumer of decoded data, slave = the decoder itself.
interface ps2_mouse_packet_decoder_if #(
  parameter int POS_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [2:0]        buttons;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic signed [3:0] dz;
  logic [1:0]        ovf;
  logic              pkt_valid;
  logic [POS_W-1:0]  pos_x;
  logic [POS_W-1:0]  pos_y;
  logic              sync_err;
  logic              timeout;

  modport master (
    output rx_data, rx_valid,
    input  buttons, dx, dy, dz, ovf, pkt_valid, pos_x, pos_y, sync_err, timeout
  );

  modport slave (
    input  rx_data, rx_valid,
    output buttons, dx, dy, dz, ovf, pkt_valid, pos_x, pos_y, sync_err, timeout
  );
endinterface

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles PS/2 mouse bytes into 3- or 4-byte packets, decodes buttons/deltas and
// tracks a clamped cursor; resyncs on a bad sync bit or an inter-byte timeout.
module ps2_mouse_packet_decoder #(
  parameter int PACKET_BYTES = 3,
  parameter int POS_W        = 10,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int TIMEOUT_CYC  = 2500000,
  parameter int TO_W         = 22
) (
  input logic CLOCK,
  input logic reset,
  ps2_mouse_packet_decoder_if.slave bus
);
  localparam int                    SW       = POS_W + 2;
  localparam logic [1:0]            LAST_IDX = 2'(PACKET_BYTES - 1);
  localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic signed [SW-1:0]  X_LIM    = SW'(X_MAX);
  localparam logic signed [SW-1:0]  Y_LIM    = SW'(Y_MAX);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    WAIT_B3 = 2'd3
  } state_t;

  state_t           state_reg, state_next, cur_state;
  logic [TO_W-1:0]  cnt_reg, cnt_next;
  logic             expire, store_en, do_decode, sync_next, timeout_next;

  logic [2:0][7:0]  pkt_byte;
  logic [3:0]       dz_raw;

  logic [2:0]        buttons_reg;
  logic signed [8:0] dx_reg, dy_reg;
  logic signed [3:0] dz_reg;
  logic [1:0]        ovf_reg;
  logic              pkt_valid_reg, sync_err_reg, timeout_reg;
  logic [POS_W-1:0]  pos_x_reg, pos_y_reg;

  // Earlier packet bytes are held in registers; the final byte is used straight off rx_data.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_byte
      if (gi < PACKET_BYTES - 1) begin : g_store
        logic [7:0] byte_reg;
        always_ff @(posedge CLOCK) begin
          if (reset) begin
            byte_reg <= '0;
          end else if (store_en && (2'(cur_state) == 2'(gi))) begin
            byte_reg <= bus.rx_data;
          end
        end
        assign pkt_byte[gi] = byte_reg;
      end else begin : g_live
        assign pkt_byte[gi] = bus.rx_data;
      end
    end

    if (PACKET_BYTES == 4) begin : g_wheel
      assign dz_raw = bus.rx_data[3:0];
    end else begin : g_no_wheel
      assign dz_raw = 4'h0;
    end
  endgenerate

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_reg <= WAIT_B0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Expiry forces the FSM back to WAIT_B0 first, so a byte arriving on that
  // same cycle is judged as a fresh byte0 candidate.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = '0;
    expire       = 1'b0;
    store_en     = 1'b0;
    do_decode    = 1'b0;
    sync_next    = 1'b0;
    timeout_next = 1'b0;

    if (state_reg != WAIT_B0) begin
      if (cnt_reg == TO_LAST) begin
        expire = 1'b1;
      end else if (!bus.rx_valid) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    cur_state = expire ? WAIT_B0 : state_reg;

    if (expire) begin
      timeout_next = 1'b1;
      state_next   = WAIT_B0;
    end

    if (bus.rx_valid) begin
      if (cur_state == WAIT_B0) begin
        if (bus.rx_data[3]) begin
          store_en   = 1'b1;
          state_next = WAIT_B1;
        end else begin
          // The timeout pulse owns this cycle; the rejected byte is still dropped.
          sync_next = !expire;
        end
      end else if (2'(cur_state) == LAST_IDX) begin
        do_decode  = pkt_byte[0][3];
        state_next = WAIT_B0;
      end else begin
        store_en   = 1'b1;
        state_next = state_t'(2'(cur_state) + 2'd1);
      end
    end
  end

  logic signed [8:0]    dx_pkt, dy_pkt;
  logic signed [SW-1:0] x_step, y_step, x_sum, y_sum;
  logic [POS_W-1:0]     x_clamp, y_clamp;

  // Wide signed sum so the clamp sees true over/underflow instead of a wrap.
  always_comb begin
    dx_pkt = {pkt_byte[0][4], pkt_byte[1]};
    dy_pkt = {pkt_byte[0][5], pkt_byte[2]};
    x_step = pkt_byte[0][6] ? '0 : {{(SW-9){dx_pkt[8]}}, dx_pkt};
    y_step = pkt_byte[0][7] ? '0 : {{(SW-9){dy_pkt[8]}}, dy_pkt};
    x_sum  = $signed({2'b00, pos_x_reg}) + x_step;
    y_sum  = $signed({2'b00, pos_y_reg}) - y_step;

    if (x_sum < 0) begin
      x_clamp = '0;
    end else if (x_sum > X_LIM) begin
      x_clamp = POS_W'(X_MAX);
    end else begin
      x_clamp = x_sum[POS_W-1:0];
    end

    if (y_sum < 0) begin
      y_clamp = '0;
    end else if (y_sum > Y_LIM) begin
      y_clamp = POS_W'(Y_MAX);
    end else begin
      y_clamp = y_sum[POS_W-1:0];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      buttons_reg   <= '0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      dz_reg        <= '0;
      ovf_reg       <= '0;
      pkt_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      pos_x_reg     <= POS_W'(X_MAX >> 1);
      pos_y_reg     <= POS_W'(Y_MAX >> 1);
    end else begin
      pkt_valid_reg <= do_decode;
      sync_err_reg  <= sync_next;
      timeout_reg   <= timeout_next;
      if (do_decode) begin
        buttons_reg <= pkt_byte[0][2:0];
        dx_reg      <= dx_pkt;
        dy_reg      <= dy_pkt;
        dz_reg      <= dz_raw;
        ovf_reg     <= pkt_byte[0][7:6];
        pos_x_reg   <= x_clamp;
        pos_y_reg   <= y_clamp;
      end
    end
  end

  assign bus.buttons   = buttons_reg;
  assign bus.dx        = dx_reg;
  assign bus.dy        = dy_reg;
  assign bus.dz        = dz_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.pkt_valid = pkt_valid_reg;
  assign bus.pos_x     = pos_x_reg;
  assign bus.pos_y     = pos_y_reg;
  assign bus.sync_err  = sync_err_reg;
  assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Drives one byte stream into a 3-byte and a 4-byte decoder and compares every
// output pulse against a packet-level reference model via per-instance queues.
module tb_ps2_mouse_packet_decoder;
  localparam int POS_W = 10;
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
  localparam int TO    = 40;
  localparam int TO_W  = 6;
  localparam int K_PKT = 0;
  localparam int K_SYNC = 1;
  localparam int K_TMO = 2;

  typedef struct {
    int kind;
    int cyc;
    int buttons;
    int dx;
    int dy;
    int dz;
    int ovf;
    int px;
    int py;
  } ev_t;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  int         cyc      = 0;
  int         checks   = 0;
  int         errors   = 0;

  ev_t        q0[$];
  ev_t        q1[$];
  logic [7:0] part [2][4];
  int         plen [2];
  int         last_c [2];
  int         mx [2];
  int         my [2];

  always #5 clk = ~clk;

  ps2_mouse_packet_decoder_if #(.POS_W(POS_W)) bus3 ();
  ps2_mouse_packet_decoder_if #(.POS_W(POS_W)) bus4 ();

  assign bus3.rx_data  = rx_data;
  assign bus3.rx_valid = rx_valid;
  assign bus4.rx_data  = rx_data;
  assign bus4.rx_valid = rx_valid;

  ps2_mouse_packet_decoder #(
    .PACKET_BYTES(3), .POS_W(POS_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .TIMEOUT_CYC(TO), .TO_W(TO_W)
  ) u3 (
    .CLOCK(clk), .reset(rst), .bus(bus3)
  );

  ps2_mouse_packet_decoder #(
    .PACKET_BYTES(4), .POS_W(POS_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .TIMEOUT_CYC(TO), .TO_W(TO_W)
  ) u4 (
    .CLOCK(clk), .reset(rst), .bus(bus4)
  );

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void push_ev(int u, ev_t e);
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int qsize(int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t pop_ev(int u);
    if (u == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int front_cyc(int u);
    return (u == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  // Reference model: a packet is a list of bytes starting with a sync-bit byte;
  // a partial list is abandoned once TO cycles pass after its latest byte.
  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      plen[u]   = 0;
      last_c[u] = 0;
      mx[u]     = X_MAX >> 1;
      my[u]     = Y_MAX >> 1;
    end
  endtask

  task automatic model_step(int u, int n);
    ev_t        e;
    logic [7:0] b0;
    bit         expired;
    e = '{default: 0};
    e.cyc = cyc;
    expired = 1'b0;
    if (plen[u] > 0 && (cyc - last_c[u]) == TO) begin
      e.kind = K_TMO;
      push_ev(u, e);
      plen[u] = 0;
      expired = 1'b1;
    end
    if (rx_valid) begin
      last_c[u] = cyc;
      if (plen[u] == 0) begin
        if (rx_data[3]) begin
          part[u][0] = rx_data;
          plen[u] = 1;
        end else if (!expired) begin
          e.kind = K_SYNC;
          push_ev(u, e);
        end
      end else begin
        part[u][plen[u]] = rx_data;
        plen[u]++;
        if (plen[u] == n) begin
          b0 = part[u][0];
          e.kind    = K_PKT;
          e.buttons = int'(b0[2:0]);
          e.ovf     = int'(b0[7:6]);
          e.dx      = int'(part[u][1]) - (b0[4] ? 256 : 0);
          e.dy      = int'(part[u][2]) - (b0[5] ? 256 : 0);
          e.dz      = 0;
          if (n == 4) e.dz = int'(part[u][3][3:0]) - (part[u][3][3] ? 16 : 0);
          if (!b0[6]) mx[u] = clampi(mx[u] + e.dx, 0, X_MAX);
          if (!b0[7]) my[u] = clampi(my[u] - e.dy, 0, Y_MAX);
          e.px = mx[u];
          e.py = my[u];
          push_ev(u, e);
          plen[u] = 0;
        end
      end
    end
  endtask

  task automatic tick(bit v, logic [7:0] d, bit r);
    rx_valid = v;
    rx_data  = d;
    rst      = r;
    if (r) begin
      model_reset();
    end else begin
      model_step(0, 3);
      model_step(1, 4);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(logic [7:0] d);
    tick(1'b1, d, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    check_int("rst_zero_u3", int'({bus3.buttons, bus3.dx, bus3.dy, bus3.dz, bus3.ovf,
                                   bus3.pkt_valid, bus3.sync_err, bus3.timeout}), 0);
    check_int("rst_zero_u4", int'({bus4.buttons, bus4.dx, bus4.dy, bus4.dz, bus4.ovf,
                                   bus4.pkt_valid, bus4.sync_err, bus4.timeout}), 0);
    check_int("rst_pos_x", int'(bus3.pos_x), X_MAX >> 1);
    check_int("rst_pos_y", int'(bus4.pos_y), Y_MAX >> 1);
  endtask

  task automatic monitor(int u, logic pv, logic se, logic tmo, logic [2:0] btn,
                         logic signed [8:0] dx, logic signed [8:0] dy, logic signed [3:0] dz,
                         logic [1:0] ovf, logic [POS_W-1:0] px, logic [POS_W-1:0] py);
    ev_t e;
    int  kind;
    int  n;
    n = int'(pv) + int'(se) + int'(tmo);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL excl u%0d cyc %0d: pkt_valid=%0b sync_err=%0b timeout=%0b, expected at most one",
               u, cyc, pv, se, tmo);
    end
    if (n > 0) begin
      kind = pv ? K_PKT : (se ? K_SYNC : K_TMO);
      checks++;
      if (qsize(u) == 0) begin
        errors++;
        $display("FAIL unexpected u%0d cyc %0d: got pulse kind %0d, expected none", u, cyc, kind);
      end else begin
        e = pop_ev(u);
        if (e.kind != kind || e.cyc != cyc - 1) begin
          errors++;
          $display("FAIL event u%0d cyc %0d: got kind %0d, expected kind %0d for input cycle %0d",
                   u, cyc, kind, e.kind, e.cyc);
        end else if (kind == K_PKT &&
                     (int'(btn) != e.buttons || int'(dx) != e.dx || int'(dy) != e.dy ||
                      int'(dz) != e.dz || int'(ovf) != e.ovf || int'(px) != e.px ||
                      int'(py) != e.py)) begin
          errors++;
          $display("FAIL pkt u%0d cyc %0d: got btn=%0d dx=%0d dy=%0d dz=%0d ovf=%0d pos=(%0d,%0d), expected btn=%0d dx=%0d dy=%0d dz=%0d ovf=%0d pos=(%0d,%0d)",
                   u, cyc, btn, dx, dy, dz, ovf, px, py,
                   e.buttons, e.dx, e.dy, e.dz, e.ovf, e.px, e.py);
        end else begin
          $display("u%0d cyc %0d kind %0d btn=%0d dx=%0d dy=%0d dz=%0d pos=(%0d,%0d)",
                   u, cyc, kind, btn, dx, dy, dz, px, py);
        end
      end
    end
    while (qsize(u) > 0 && front_cyc(u) < cyc - 1) begin
      e = pop_ev(u);
      checks++;
      errors++;
      $display("FAIL missing u%0d cyc %0d: got no pulse, expected kind %0d for input cycle %0d",
               u, cyc, e.kind, e.cyc);
    end
  endtask

  always @(negedge clk)
    monitor(0, bus3.pkt_valid, bus3.sync_err, bus3.timeout, bus3.buttons, bus3.dx, bus3.dy,
            bus3.dz, bus3.ovf, bus3.pos_x, bus3.pos_y);

  always @(negedge clk)
    monitor(1, bus4.pkt_valid, bus4.sync_err, bus4.timeout, bus4.buttons, bus4.dx, bus4.dy,
            bus4.dz, bus4.ovf, bus4.pos_x, bus4.pos_y);

  initial begin
    model_reset();
    do_reset();

    send(8'h08); send(8'h05); send(8'h03);
    check_int("t1_dx", int'(bus3.dx), 5);
    check_int("t1_pos_x", int'(bus3.pos_x), 324);
    check_int("t1_pos_y", int'(bus3.pos_y), 236);

    send(8'h39); send(8'hFB); send(8'hFE);
    check_int("t2_buttons", int'(bus3.buttons), 1);
    check_int("t2_pos_x", int'(bus3.pos_x), 319);
    check_int("t2_pos_y", int'(bus3.pos_y), 238);

    repeat (4) begin send(8'h08); send(8'h7F); send(8'h00); end
    check_int("t3_sat_hi", int'(bus3.pos_x), X_MAX);
    repeat (6) begin send(8'h18); send(8'h80); send(8'h00); end
    check_int("t3_sat_lo", int'(bus3.pos_x), 0);

    send(8'h05);
    check_int("t4_sync_err", int'(bus3.sync_err), 1);
    send(8'h08); send(8'h01); send(8'h01);
    check_int("t4_dx", int'(bus3.dx), 1);

    send(8'h08); send(8'h01);
    idle(TO + 2);
    send(8'h08); send(8'h02); send(8'h02);
    check_int("t5_dx", int'(bus3.dx), 2);

    do_reset();
    send(8'h08); send(8'h00); send(8'h00); send(8'h0F);
    check_int("t6_dz", int'(bus4.dz), -1);
    send(8'h08); send(8'h00); send(8'h00);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      int         r;
      int         gap;
      logic [7:0] d;
      r = int'($urandom_range(0, 99));
      if (r < 65)      gap = 0;
      else if (r < 88) gap = int'($urandom_range(1, 3));
      else if (r < 92) gap = TO - 2;
      else if (r < 96) gap = TO - 1;
      else             gap = TO + int'($urandom_range(0, 4));
      idle(gap);
      d = 8'($urandom);
      if ($urandom_range(0, 9) < 8) d[3] = 1'b1;
      send(d);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    idle(TO + 5);
    check_int("drain_u3", q0.size(), 0);
    check_int("drain_u4", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
